// File: rtl/lsu_dccm_bank_arb.sv
// Purpose : multi-bank DCCM port controller; arbitrates a load read (lo/hi bank) against a store-buffer commit.
// Latency : grants and bank drive are combinational; read data is registered RD_LAT+1 cycles after ld_gnt.
// Backpress: a conflicting store loses to the load until STARVE_MAX denials, then it is forced; freeze blocks all grants.
//
// Ports:
//   clk, rst_l                     core clock, async active-low reset
//   freeze                         suppresses new grants (in-flight reads still return)
//   ld_req_vld/ld_addr_lo/hi/ld_gnt load read request (held until granted) and grant
//   st_req_vld/st_addr/st_data/st_ecc/st_commit store commit request and pop
//   dccm_rden/wren/addr/wr_data    per-bank SRAM controls
//   dccm_rd_data                   per-bank SRAM read data, valid RD_LAT cycles after rden
//   ld_rvalid/ld_rdata_*/ld_recc_* registered read result
//   st_force                       starve counter saturated
module lsu_dccm_bank_arb #(
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_BITS  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_l,
  input  logic                                      freeze,
  input  logic                                      ld_req_vld,
  input  logic [ADDR_BITS-1:0]                      ld_addr_lo,
  input  logic [ADDR_BITS-1:0]                      ld_addr_hi,
  output logic                                      ld_gnt,
  input  logic                                      st_req_vld,
  input  logic [ADDR_BITS-1:0]                      st_addr,
  input  logic [DATA_WIDTH-1:0]                     st_data,
  input  logic [ECC_WIDTH-1:0]                      st_ecc,
  output logic                                      st_commit,
  output logic [NUM_BANKS-1:0]                      dccm_rden,
  output logic [NUM_BANKS-1:0]                      dccm_wren,
  output logic [NUM_BANKS*ADDR_BITS-1:0]            dccm_addr,
  output logic [DATA_WIDTH+ECC_WIDTH-1:0]           dccm_wr_data,
  input  logic [NUM_BANKS*(DATA_WIDTH+ECC_WIDTH)-1:0] dccm_rd_data,
  output logic                                      ld_rvalid,
  output logic [DATA_WIDTH-1:0]                     ld_rdata_lo,
  output logic [DATA_WIDTH-1:0]                     ld_rdata_hi,
  output logic [ECC_WIDTH-1:0]                      ld_recc_lo,
  output logic [ECC_WIDTH-1:0]                      ld_recc_hi,
  output logic                                      st_force
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int FDATA     = DATA_WIDTH + ECC_WIDTH;

  // One tracking-pipeline stage: which banks to pick up when the SRAM data lands.
  typedef struct packed {
    logic                 vld;
    logic [BANK_BITS-1:0] bl;
    logic [BANK_BITS-1:0] bh;
  } trk_t;

  logic [BANK_BITS-1:0] bl, bh, bs;
  logic                 conflict;
  logic                 grant_en;
  logic [3:0]           starve_cnt;
  trk_t                 trk [RD_LAT];
  trk_t                 fin;
  logic [FDATA-1:0]     rd_bank [NUM_BANKS];

  assign bl = ld_addr_lo[BYTE_BITS +: BANK_BITS];
  assign bh = ld_addr_hi[BYTE_BITS +: BANK_BITS];
  assign bs = st_addr[BYTE_BITS +: BANK_BITS];

  assign conflict = ld_req_vld & st_req_vld & ((bs == bl) | (bs == bh));
  assign st_force = (starve_cnt == 4'(STARVE_MAX));

  // Grants are held off while in reset so every output reads 0.
  assign grant_en  = rst_l & ~freeze;
  assign ld_gnt    = grant_en & ld_req_vld & ~(conflict & st_force);
  assign st_commit = grant_en & st_req_vld & (~conflict | st_force);

  assign dccm_wr_data = rst_l ? {st_ecc, st_data} : '0;

  // A granted load and a committed store never share a bank (that would be a
  // conflict), so the priority order below only matters for bl vs bh.
  always_comb begin
    dccm_rden = '0;
    dccm_wren = '0;
    dccm_addr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (ld_gnt && (bl == BANK_BITS'(b))) begin
        dccm_rden[b] = 1'b1;
        dccm_addr[b*ADDR_BITS +: ADDR_BITS] = ld_addr_lo;
      end else if (ld_gnt && (bh == BANK_BITS'(b))) begin
        dccm_rden[b] = 1'b1;
        dccm_addr[b*ADDR_BITS +: ADDR_BITS] = ld_addr_hi;
      end else if (st_commit && (bs == BANK_BITS'(b))) begin
        dccm_wren[b] = 1'b1;
        dccm_addr[b*ADDR_BITS +: ADDR_BITS] = st_addr;
      end
    end
  end

  // Consecutive store denials; saturates so st_force stays up until the commit.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      starve_cnt <= '0;
    end else if (!freeze) begin
      if (st_commit || !st_req_vld) begin
        starve_cnt <= '0;
      end else if (!st_force) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Free-running delay line matching the SRAM read latency; freeze never stalls it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < RD_LAT; i++) trk[i] <= '0;
    end else begin
      trk[0] <= {ld_gnt, bl, bh};
      for (int i = 1; i < RD_LAT; i++) trk[i] <= trk[i-1];
    end
  end

  assign fin = trk[RD_LAT-1];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) rd_bank[b] = dccm_rd_data[b*FDATA +: FDATA];
  end

  // When bh==bl only one bank was read, and selecting bank bh yields that same bank.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ld_rvalid   <= 1'b0;
      ld_rdata_lo <= '0;
      ld_rdata_hi <= '0;
      ld_recc_lo  <= '0;
      ld_recc_hi  <= '0;
    end else begin
      ld_rvalid <= fin.vld;
      if (fin.vld) begin
        ld_rdata_lo <= rd_bank[fin.bl][DATA_WIDTH-1:0];
        ld_recc_lo  <= rd_bank[fin.bl][FDATA-1:DATA_WIDTH];
        ld_rdata_hi <= rd_bank[fin.bh][DATA_WIDTH-1:0];
        ld_recc_hi  <= rd_bank[fin.bh][FDATA-1:DATA_WIDTH];
      end
    end
  end

endmodule

// File: doc/lsu_dccm_bank_arb.md
# lsu_dccm_bank_arb

Parametrised multi-bank DCCM port controller for the LSU pipe. It arbitrates each cycle between a load read (lo and hi bank, for unaligned accesses) and a store-buffer commit. Conflicts are detected per bank, and a starvation counter guarantees forward progress for stores. Read data returns through a configurable-latency tracking pipeline and is registered into a stable output. It generalises the single-bank-pair DCCM control to N banks and variable SRAM read latency.

## Interface
Parameters:
- NUM_BANKS, 2, number of DCCM banks; power of 2, range 2..8; BANK_BITS = log2(NUM_BANKS)
- ADDR_BITS, 16, DCCM byte-address width
- DATA_WIDTH, 32, data bits per bank; BYTE_BITS = log2(DATA_WIDTH/8)
- ECC_WIDTH, 7, ECC bits per bank; FDATA = DATA_WIDTH + ECC_WIDTH
- RD_LAT, 1, SRAM read latency in cycles; range 1..3
- STARVE_MAX, 4, consecutive store denials before the store is forced; range 1..15

Ports:
- clk  in  1  core clock
- rst_l  in  1  reset; asynchronous, active-low
- freeze  in  1  blocks new grants; in-flight reads still complete
- ld_req_vld  in  1  load read request; must be held until ld_gnt
- ld_addr_lo  in  ADDR_BITS  start byte address
- ld_addr_hi  in  ADDR_BITS  end byte address
- ld_gnt  out  1  load read issued this cycle
- st_req_vld  in  1  store buffer has an entry to commit
- st_addr  in  ADDR_BITS  store address, bank-aligned
- st_data  in  DATA_WIDTH  store data
- st_ecc  in  ECC_WIDTH  store ECC
- st_commit  out  1  store written this cycle; store buffer pops
- dccm_rden  out  NUM_BANKS  per-bank read enable
- dccm_wren  out  NUM_BANKS  per-bank write enable
- dccm_addr  out  NUM_BANKS*ADDR_BITS  per-bank address; slice b at [b*ADDR_BITS +: ADDR_BITS]
- dccm_wr_data  out  FDATA  {st_ecc, st_data}, shared by all banks
- dccm_rd_data  in  NUM_BANKS*FDATA  per-bank read data, valid RD_LAT cycles after rden
- ld_rvalid  out  1  one-cycle pulse: output data updated
- ld_rdata_lo, ld_rdata_hi  out  DATA_WIDTH  registered lo- and hi-bank data
- ld_recc_lo, ld_recc_hi  out  ECC_WIDTH  registered lo- and hi-bank ECC
- st_force  out  1  starve counter at STARVE_MAX (debug/perf)

## Operation
- Bank index fields: bl = ld_addr_lo[BYTE_BITS +: BANK_BITS]; bh = the same field of ld_addr_hi; bs = the same field of st_addr.
- Conflict condition: ld_req_vld & st_req_vld & (bs==bl | bs==bh).
- Grant rules (all gated by ~freeze):
  - No conflict: ld_gnt = ld_req_vld, st_commit = st_req_vld, both in the same cycle.
  - Conflict with st_force=0: load wins; st_commit=0.
  - Conflict with st_force=1: store wins; ld_gnt=0.
- Bank drive on a load grant:
  - dccm_rden[bl]=1 with address ld_addr_lo.
  - If bh!=bl: dccm_rden[bh]=1 with address ld_addr_hi.
  - If bh==bl: one read only; hi output is copied from the lo bank.
- Bank drive on a store commit: dccm_wren[bs]=1 with address st_addr.
- Unused bank address slices are 0.
- Starve counter (4-bit, saturating at STARVE_MAX):
  - Increments when st_req_vld & ~st_commit & ~freeze.
  - Clears on st_commit or ~st_req_vld.
  - Holds during freeze.
  - st_force = (cnt == STARVE_MAX).
- Tracking pipeline: RD_LAT stages, each holding {valid, bl, bh}, entering on ld_gnt. Stages always advance; freeze does not stall them.
- On the final stage valid:
  - ld_rdata_lo/ld_recc_lo capture bank bl.
  - ld_rdata_hi/ld_recc_hi capture bank bh (bank bl when bh==bl).
  - ld_rvalid pulses.
- Output data holds between captures.
- Reset: all outputs 0, counter 0, pipeline valids 0. Reads in flight at reset are discarded; no ld_rvalid follows reset release.

## Timing
- Grant is combinational from the request in the same cycle T.
- dccm_rd_data is sampled at T+RD_LAT.
- ld_rvalid and the data are high/valid in cycle T+RD_LAT+1.
- Throughput is one load grant per cycle. Back-to-back grants produce back-to-back ld_rvalid pulses.
- Store commit writes in cycle T, with no pipeline.
- Maximum store wait under continuous conflicting loads: STARVE_MAX denied cycles, then commit on the next cycle.
- freeze asserted in cycle T: no grants in T. Reads granted at T-1 or earlier still return on schedule.

## Test plan
- NUM_BANKS=4, load lo=0x004 (bank1), hi=0x004; store 0x008 (bank2) -> ld_gnt=1 and st_commit=1 in the same cycle; rden=4'b0010, wren=4'b0100; ld_rvalid 2 cycles later (RD_LAT=1) with hi==lo data.
- Unaligned load lo=0x00E, hi=0x011 (banks 3, 0), store 0x010 (bank0) -> load granted, store denied, counter=1; rden=4'b1001.
- STARVE_MAX=4, continuous conflicting loads with a pending store -> loads granted for 4 cycles; 5th cycle st_force=1, st_commit=1, ld_gnt=0; counter=0 next cycle.
- RD_LAT=3, loads granted in cycles 10, 11, 12 with distinct bank data -> ld_rvalid in 14, 15, 16 with matching data order.
- Load granted in cycle 10, freeze=1 in cycles 11-13 with requests pending -> no grants in 11-13; ld_rvalid still at 10+RD_LAT+1; counter frozen.
- rst_l low for one cycle right after a grant (RD_LAT=2) -> all outputs 0; no ld_rvalid for that load after release.
